// File: rtl/seq_shift_rotate_unit_pkg.sv
// Shared encodings for the sequential shift/rotate engine and its one-bit step.
package seq_shift_rotate_unit_pkg;

    // Operation codes; 5..7 are treated as PASS (result equals operand A).
    typedef enum logic [2:0] {
        OpSll = 3'd0,
        OpSrl = 3'd1,
        OpSra = 3'd2,
        OpRol = 3'd3,
        OpRor = 3'd4
    } op_e;

    typedef enum logic {
        StIdle  = 1'b0,
        StShift = 1'b1
    } state_e;

endpackage

// File: rtl/seq_shift_rotate_unit_step.sv
// Combinational one-position step of the shift/rotate engine.
module seq_shift_rotate_unit_step
    import seq_shift_rotate_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [2:0]       op_i,
    output logic [WIDTH-1:0] acc_o
);

    // Move the accumulator by one bit according to the captured operation.
    always_comb begin
        acc_o = acc_i;
        case (op_e'(op_i))
            OpSll:   acc_o = {acc_i[WIDTH-2:0], 1'b0};
            OpSrl:   acc_o = {1'b0, acc_i[WIDTH-1:1]};
            OpSra:   acc_o = {acc_i[WIDTH-1], acc_i[WIDTH-1:1]};
            OpRol:   acc_o = {acc_i[WIDTH-2:0], acc_i[WIDTH-1]};
            OpRor:   acc_o = {acc_i[0], acc_i[WIDTH-1:1]};
            default: acc_o = acc_i;
        endcase
    end

endmodule

// File: rtl/seq_shift_rotate_unit.sv
// Multi-cycle shift/rotate engine: one bit position per clock, start/busy/done handshake.
module seq_shift_rotate_unit
    import seq_shift_rotate_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] res,
    output logic             busy,
    output logic             done
);

    state_e           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [AMT_W-1:0] cnt_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] res_q;
    logic             busy_q;
    logic             done_q;

    // Only the low AMT_W bits of B form the amount.
    logic unused_b_hi;
    assign unused_b_hi = ^B[WIDTH-1:AMT_W];

    seq_shift_rotate_unit_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_i (acc_q),
        .op_i  (op_q),
        .acc_o (acc_d)
    );

    // Control FSM with registered outputs; done is a single-cycle pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        acc_q   <= A;
                        cnt_q   <= B[AMT_W-1:0];
                        op_q    <= op;
                        busy_q  <= 1'b1;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    if (cnt_q == '0) begin
                        res_q   <= acc_q;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q - AMT_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign res  = res_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_seq_shift_rotate_unit.sv
// Self-checking bench: vector table plus hand sequences, results checked via a scoreboard.
module tb_seq_shift_rotate_unit;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        logic [7:0] res;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] op = '0;
    logic [7:0] A = '0;
    logic [7:0] B = '0;
    logic [7:0] res;
    logic       busy;
    logic       done;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[$];

    seq_shift_rotate_unit #(
        .WIDTH (8),
        .AMT_W (3)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .res   (res),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Barrel-style reference for one whole operation.
    function automatic logic [7:0] model(input logic [2:0] o, input logic [7:0] a,
                                         input logic [7:0] b);
        int unsigned n;
        logic [15:0] w;
        n = int'(b[2:0]);
        case (o)
            3'd0: return a << n;
            3'd1: return a >> n;
            3'd2: return 8'($signed(a) >>> n);
            3'd3: begin w = {a, a} << n; return w[15:8]; end
            3'd4: begin w = {a, a} >> n; return w[7:0]; end
            default: return a;
        endcase
    endfunction

    // Monitor: busy/done exclusion and scoreboard pop on every done pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy && done) chk("busy_done_overlap", 1, 0);
            if (done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("res", int'(res), int'(mon_e.res));
                    chk("done_cycle", cyc, mon_e.cyc);
                end
            end
        end
    end

    // Issue one op from idle; inputs are scrambled while busy to show they are not re-sampled.
    task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp);
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0; op = 3'($urandom); A = 8'($urandom); B = 8'($urandom);
        sb.push_back('{exp, cyc + int'(b[2:0]) + 1});
        chk("busy_after_start", int'(busy), 1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 1, 0);
    endtask

    initial begin
        int   d0;
        bit   seen;
        logic [2:0] ro;
        logic [7:0] ra, rb;

        vecs.push_back('{3'd0, 8'h81, 8'h01, 8'h02});
        vecs.push_back('{3'd2, 8'h90, 8'h03, 8'hF2});
        vecs.push_back('{3'd1, 8'hFF, 8'h07, 8'h01});
        vecs.push_back('{3'd3, 8'h96, 8'h0C, 8'h69});
        vecs.push_back('{3'd4, 8'h01, 8'h01, 8'h80});
        vecs.push_back('{3'd4, 8'h96, 8'h02, 8'hA5});
        vecs.push_back('{3'd3, 8'h80, 8'h01, 8'h01});
        vecs.push_back('{3'd2, 8'h7F, 8'h07, 8'h00});
        vecs.push_back('{3'd0, 8'h01, 8'hFF, 8'h80});
        vecs.push_back('{3'd1, 8'h80, 8'h05, 8'h04});
        vecs.push_back('{3'd5, 8'h5A, 8'h03, 8'h5A});
        vecs.push_back('{3'd7, 8'h33, 8'h07, 8'h33});

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_res", int'(res), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
            wait_idle();
        end

        // Amount 0: busy for exactly one cycle, done on the next
        run_op(3'd2, 8'h80, 8'h00, 8'h80);
        @(negedge clk);
        chk("amt0_busy_dropped", int'(busy), 0);
        chk("amt0_done", int'(done), 1);
        wait_idle();

        // Start while busy is ignored: only one done pulse
        d0 = done_cnt;
        run_op(3'd0, 8'h01, 8'h07, 8'h80);
        @(negedge clk);
        start = 1'b1; op = 3'd1; A = 8'hFF; B = 8'h01;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);
        chk("busy_start_single_done", done_cnt - d0, 1);

        // Start in the done cycle is accepted; res holds the previous result meanwhile
        run_op(3'd1, 8'hF0, 8'h02, 8'h3C);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", int'(seen), 1);
        start = 1'b1; op = 3'd3; A = 8'h0F; B = 8'h03;
        @(negedge clk);
        start = 1'b0;
        sb.push_back('{8'h78, cyc + 4});
        chk("done_cycle_accept_busy", int'(busy), 1);
        chk("done_cycle_res_held", int'(res), 8'h3C);
        wait_idle();

        // Reset mid-operation: abort, no done
        @(negedge clk);
        start = 1'b1; op = 3'd0; A = 8'hFF; B = 8'h07;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_res", int'(res), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        d0 = done_cnt;
        repeat (12) @(negedge clk);
        chk("midrst_no_done", done_cnt - d0, 0);

        // Random ops against the barrel-style reference
        for (int i = 0; i < 60; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op(ro, ra, rb, model(ro, ra, rb));
            wait_idle();
        end

        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
